alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL provide parameter SIG_W, default 6, width of function code and of every routed signal.
REQ-002 SHALL provide parameter MUL_CYCLES, default 32, MULTU iteration count, legal range 1..255.
REQ-003 SHALL provide parameter DIV_CYCLES, default 32, DIVU iteration count, legal range 1..255.
REQ-004 SHALL provide parameter DIV_EN, default 1; 0 treats DIVU as single-cycle pass-through.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 funct  input  SIG_W  function code of offered op.
REQ-008 op_valid  input  1  funct is valid this cycle.
REQ-009 op_ready  output  1  sequencer accepts an op this cycle.
REQ-010 sig_alu, sig_sht, sig_mul, sig_mux  output  SIG_W each  registered routed code, all four identical.
REQ-011 mul_start  output  1  one-cycle pulse starting multiplier/divider datapath.
REQ-012 busy  output  1  multi-cycle op in progress.
REQ-013 hilo_we  output  1  one-cycle HI/LO write-enable pulse.
REQ-014 done  output  1  one-cycle completion pulse for any accepted op.

Function
REQ-015 SHALL implement states IDLE and RUN; op_ready = (state==IDLE), combinational.
REQ-016 Accept = op_valid && op_ready, sampled at rising edge.
REQ-017 IDLE, accept, funct not MULTU(011001)/DIVU(011011): sig_* <= funct next edge, done=1 that cycle, stay IDLE; latency 1 cycle.
REQ-018 IDLE, no accept: sig_* <= NOP (000000), done=0.
REQ-019 IDLE, accept of MULTU (or DIVU with DIV_EN=1): edge E0 -> state RUN, counter <= 1, sig_* <= funct, mul_start=1, busy=1.
REQ-020 RUN: each edge counter += 1, sig_* hold opcode, mul_start=0.
REQ-021 RUN, edge where counter == N (N=MUL_CYCLES or DIV_CYCLES per latched op): sig_* <= HILO_OPEN (111111), hilo_we=1, done=1, busy=0, state IDLE, counter <= 0.
REQ-022 N==1: HILO_OPEN occurs at E1, the edge after E0.
REQ-023 op_valid during RUN SHALL be ignored; upstream holds funct until op_ready.
REQ-024 funct changes during RUN SHALL not affect latched opcode or count.
REQ-025 HILO_OPEN cycle is also IDLE; a new accept there takes effect at next edge (back-to-back MULTU permitted, no bubble beyond the HILO_OPEN cycle).
REQ-026 Unknown funct codes SHALL pass through as single-cycle ops.
REQ-027 Counter width SHALL be 8 bits; no wrap possible within legal range.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, counter 0, sig_* 000000, mul_start 0, busy 0, hilo_we 0, done 0, op_ready 1.
REQ-029 Reset during RUN SHALL abort the op with no hilo_we or done pulse.
REQ-030 First accept possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Opcode constants (NOP, ADD, SUB, AND, OR, SLT, SLL, MULTU, DIVU, MFHI, MFLO, HILO_OPEN) and state enum SHALL live in shared package alu_pkg.
REQ-032 Iteration counter SHALL be sub-module iter_counter (load, enable, terminal-count compare); remainder is a single FSM.

Verification
REQ-033 Reset: rst_n=0 mid-cycle -> all outputs 0 and op_ready=1 without waiting for clk.
REQ-034 ADD(100000) valid one cycle -> sig_*=100000 next edge, done=1, then NOP.
REQ-035 MULTU, MUL_CYCLES=32 -> mul_start at E0, busy for 32 cycles, sig_*=111111 plus hilo_we at E32, op_ready=0 E0..E31.
REQ-036 SUB offered during MULTU RUN -> ignored until E32, accepted at E33, sig_*=100010 at E33.
REQ-037 DIVU with DIV_CYCLES=4 then rst_n=0 at E2 -> no hilo_we, state IDLE; repeat with DIV_EN=0 -> single-cycle, no mul_start.
REQ-038 Two back-to-back MULTU, MUL_CYCLES=1 -> HILO_OPEN at E1 and E3, two mul_start pulses.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encodings for the ALU op sequencer.
// SLL and NOP share the all-zero function code, as in the MIPS encoding.
package alu_pkg;

    localparam logic [5:0] FN_NOP       = 6'b000000;
    localparam logic [5:0] FN_SLL       = 6'b000000;
    localparam logic [5:0] FN_ADD       = 6'b100000;
    localparam logic [5:0] FN_SUB       = 6'b100010;
    localparam logic [5:0] FN_AND       = 6'b100100;
    localparam logic [5:0] FN_OR        = 6'b100101;
    localparam logic [5:0] FN_SLT       = 6'b101010;
    localparam logic [5:0] FN_MFHI      = 6'b010000;
    localparam logic [5:0] FN_MFLO      = 6'b010010;
    localparam logic [5:0] FN_MULTU     = 6'b011001;
    localparam logic [5:0] FN_DIVU      = 6'b011011;
    localparam logic [5:0] FN_HILO_OPEN = 6'b111111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for multi-cycle ops: load starts at 1 and captures the
// iteration limit, tc_o flags that the count has reached that limit.
module iter_counter
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;

    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        if (load_i) begin
            count_d = CNT_W'(1);
            limit_d = limit_i;
        end else if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            limit_q <= '0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

    assign tc_o = (count_q == limit_q);

endmodule

// File: rtl/alu_op_sequencer.sv
// Routes ALU function codes to the datapath units; MULTU/DIVU run for a fixed
// number of iterations and finish with a HILO_OPEN cycle that writes HI/LO.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int SIG_W      = 6,
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32,
    parameter int DIV_EN     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SIG_W-1:0] funct,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [SIG_W-1:0] sig_alu,
    output logic [SIG_W-1:0] sig_sht,
    output logic [SIG_W-1:0] sig_mul,
    output logic [SIG_W-1:0] sig_mux,
    output logic             mul_start,
    output logic             busy,
    output logic             hilo_we,
    output logic             done,
    output logic             dbg_state
);

    localparam logic [SIG_W-1:0] F_NOP   = SIG_W'(FN_NOP);
    localparam logic [SIG_W-1:0] F_MULTU = SIG_W'(FN_MULTU);
    localparam logic [SIG_W-1:0] F_DIVU  = SIG_W'(FN_DIVU);
    localparam logic [SIG_W-1:0] F_HILO  = {SIG_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             mul_start_q, mul_start_d;
    logic             busy_q, busy_d;
    logic             hilo_we_q, hilo_we_d;
    logic             done_q, done_d;

    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_limit;

    // Handshake: an op transfers on a rising edge where op_valid && op_ready;
    // upstream keeps funct stable until then, and op_valid is ignored in RUN.
    assign op_ready = (state_q == ST_IDLE);
    assign accept   = op_valid && op_ready;

    assign is_mul    = (funct == F_MULTU);
    assign is_div    = (DIV_EN != 0) && (funct == F_DIVU);
    assign cnt_limit = is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);

    always_comb begin
        state_d     = state_q;
        sig_d       = F_NOP;
        mul_start_d = 1'b0;
        busy_d      = busy_q;
        hilo_we_d   = 1'b0;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (accept) begin
                    sig_d = funct;
                    if (is_mul || is_div) begin
                        state_d     = ST_RUN;
                        cnt_load    = 1'b1;
                        mul_start_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // The routed code doubles as the latched opcode while running.
                sig_d = sig_q;
                if (cnt_tc) begin
                    state_d   = ST_IDLE;
                    sig_d     = F_HILO;
                    hilo_we_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    cnt_clr   = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sig_q       <= '0;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
            hilo_we_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            mul_start_q <= mul_start_d;
            busy_q      <= busy_d;
            hilo_we_q   <= hilo_we_d;
            done_q      <= done_d;
        end
    end

    iter_counter u_iter_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (cnt_load),
        .en_i    (cnt_en),
        .clr_i   (cnt_clr),
        .limit_i (cnt_limit),
        .tc_o    (cnt_tc)
    );

    assign sig_alu   = sig_q;
    assign sig_sht   = sig_q;
    assign sig_mul   = sig_q;
    assign sig_mux   = sig_q;
    assign mul_start = mul_start_q;
    assign busy      = busy_q;
    assign hilo_we   = hilo_we_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (long MULTU with DIVU enabled,
// single-iteration MULTU with DIVU disabled) checked cycle by cycle.
module tb_alu_op_sequencer;

    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_HILO  = 6'b111111;

    localparam int A_MUL = 32;
    localparam int A_DIV = 4;
    localparam int A_EN  = 1;
    localparam int B_MUL = 1;
    localparam int B_DIV = 4;
    localparam int B_EN  = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [5:0] a_funct = '0, b_funct = '0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, b_ready;
    logic [5:0] a_alu, a_sht, a_mul, a_mux, b_alu, b_sht, b_mul, b_mux;
    logic       a_ms, a_busy, a_hw, a_done, a_st;
    logic       b_ms, b_busy, b_hw, b_done, b_st;

    // expected vector: {sig[5:0], mul_start, busy, hilo_we, done}
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.SIG_W(6), .MUL_CYCLES(A_MUL), .DIV_CYCLES(A_DIV), .DIV_EN(A_EN)) dut_a (
        .clk(clk), .rst_n(rst_n), .funct(a_funct), .op_valid(a_valid), .op_ready(a_ready),
        .sig_alu(a_alu), .sig_sht(a_sht), .sig_mul(a_mul), .sig_mux(a_mux),
        .mul_start(a_ms), .busy(a_busy), .hilo_we(a_hw), .done(a_done), .dbg_state(a_st)
    );

    alu_op_sequencer #(.SIG_W(6), .MUL_CYCLES(B_MUL), .DIV_CYCLES(B_DIV), .DIV_EN(B_EN)) dut_b (
        .clk(clk), .rst_n(rst_n), .funct(b_funct), .op_valid(b_valid), .op_ready(b_ready),
        .sig_alu(b_alu), .sig_sht(b_sht), .sig_mul(b_mul), .sig_mux(b_mux),
        .mul_start(b_ms), .busy(b_busy), .hilo_we(b_hw), .done(b_done), .dbg_state(b_st)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_vec(input int inst, input logic [9:0] v);
        if (inst == 0) qa.push_back(v);
        else qb.push_back(v);
    endtask

    // The full output trace of one accepted op, cycle by cycle after acceptance.
    task automatic push_trace(input int inst, input logic [5:0] f);
        int  n;
        bit  multi;
        int  mul_n = (inst == 0) ? A_MUL : B_MUL;
        int  div_n = (inst == 0) ? A_DIV : B_DIV;
        bit  div_en = (inst == 0) ? (A_EN != 0) : (B_EN != 0);
        multi = (f == OP_MULTU) || (f == OP_DIVU && div_en);
        n = (f == OP_MULTU) ? mul_n : div_n;
        if (multi) begin
            push_vec(inst, {f, 4'b1100});
            for (int i = 1; i < n; i++) push_vec(inst, {f, 4'b0100});
            push_vec(inst, {OP_HILO, 4'b0011});
        end else begin
            push_vec(inst, {f, 4'b0001});
        end
    endtask

    task automatic check_outputs(input logic [9:0] ea, input logic [9:0] eb);
        check("a_out", {22'd0, a_alu, a_ms, a_busy, a_hw, a_done}, {22'd0, ea});
        check("a_sig_copies", {14'd0, a_sht, a_mul, a_mux}, {14'd0, ea[9:4], ea[9:4], ea[9:4]});
        check("b_out", {22'd0, b_alu, b_ms, b_busy, b_hw, b_done}, {22'd0, eb});
        check("b_sig_copies", {14'd0, b_sht, b_mul, b_mux}, {14'd0, eb[9:4], eb[9:4], eb[9:4]});
    endtask

    // One clock: called just after a falling edge, returns just after the next one.
    task automatic step(input logic av, input logic [5:0] af, input logic bv, input logic [5:0] bf);
        logic [9:0] ea, eb;
        bit ra, rb;
        a_valid = av; a_funct = af;
        b_valid = bv; b_funct = bf;
        #1;
        ra = (qa.size() == 0);
        rb = (qb.size() == 0);
        check("a_ready", {31'd0, a_ready}, {31'd0, ra});
        check("b_ready", {31'd0, b_ready}, {31'd0, rb});
        if (av && ra) push_trace(0, af);
        if (bv && rb) push_trace(1, bf);
        ea = (qa.size() != 0) ? qa.pop_front() : 10'd0;
        eb = (qb.size() != 0) ? qb.pop_front() : 10'd0;
        @(posedge clk);
        @(negedge clk);
        check_outputs(ea, eb);
    endtask

    task automatic mid_cycle_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(10'd0, 10'd0);
        check("a_ready_rst", {31'd0, a_ready}, 32'd1);
        check("b_ready_rst", {31'd0, b_ready}, 32'd1);
        qa.delete();
        qb.delete();
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs(10'd0, 10'd0);
        rst_n = 1'b1;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] pool[8];
        pool = '{OP_ADD, OP_SUB, OP_AND, OP_MFHI, OP_MULTU, OP_DIVU, OP_DIVU, 6'b000000};
        if ($urandom_range(0, 4) == 0) return 6'($urandom_range(0, 63));
        return pool[$urandom_range(0, 7)];
    endfunction

    initial begin
        #1;
        check_outputs(10'd0, 10'd0);
        check("a_ready_init", {31'd0, a_ready}, 32'd1);
        check("b_ready_init", {31'd0, b_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, OP_ADD, 1'b1, OP_ADD);
        step(1'b0, OP_ADD, 1'b0, OP_ADD);

        // MULTU with SUB waiting behind it
        step(1'b1, OP_MULTU, 1'b1, OP_MULTU);
        for (int i = 0; i < 34; i++) step(1'b1, OP_SUB, 1'b1, OP_SUB);
        step(1'b0, OP_SUB, 1'b0, OP_SUB);

        // back-to-back MULTU
        for (int i = 0; i < 5; i++) step(1'b1, OP_MULTU, 1'b1, OP_MULTU);
        step(1'b0, OP_ADD, 1'b0, OP_ADD);
        step(1'b0, OP_ADD, 1'b0, OP_ADD);
        step(1'b0, OP_ADD, 1'b0, OP_ADD);

        // DIVU aborted by reset mid-run
        step(1'b1, OP_DIVU, 1'b1, OP_DIVU);
        step(1'b0, OP_DIVU, 1'b0, OP_DIVU);
        mid_cycle_reset();
        step(1'b1, OP_DIVU, 1'b1, OP_DIVU);
        for (int i = 0; i < 6; i++) step(1'b0, OP_ADD, 1'b0, OP_ADD);

        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), rand_op(), 1'($urandom_range(0, 1)), rand_op());
            if ($urandom_range(0, 99) == 0) mid_cycle_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
